// File: rtl/tx_fifo_pkg.sv
// Shared constants, write-FSM encoding and width helpers for the transmit frame FIFO.
// The statistics ports and counters exist only when TX_FRAME_FIFO_STATS_EN is defined.
package tx_fifo_pkg;

  localparam int unsigned TX_DATA_W   = 8;
  localparam int unsigned TX_WORD_W   = TX_DATA_W + 1;
  localparam int unsigned TX_LAST_BIT = TX_DATA_W;
  localparam int unsigned STATS_W     = 16;

  typedef enum logic [0:0] {
    ST_PASS,
    ST_DROP
  } wr_state_e;

  // Word and tlast-bit position for a non-default byte-lane width.
  function automatic int unsigned tx_word_w(input int unsigned dw);
    return dw + 1;
  endfunction

  function automatic int unsigned tx_last_bit(input int unsigned dw);
    return dw;
  endfunction

endpackage

// File: rtl/tx_fifo_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// The read register only updates on re, so rdata holds between reads.
module tx_fifo_ram #(
  parameter int unsigned Width = 9,
  parameter int unsigned Depth = 2048,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/tx_frame_fifo.sv
// Store-and-forward TX frame FIFO: frames are released only once fully stored; bad frames dropped.
// Optional statistics counters are enabled by defining TX_FRAME_FIFO_STATS_EN.
module tx_frame_fifo
  import tx_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned PTR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  drop,
  output logic                  frame_avail
`ifdef TX_FRAME_FIFO_STATS_EN
  ,
  output logic [STATS_W-1:0]    frames_sent,
  output logic [STATS_W-1:0]    frames_dropped
`endif
);

  localparam int unsigned WordW   = tx_word_w(DATA_WIDTH);
  localparam int unsigned LastBit = tx_last_bit(DATA_WIDTH);
  localparam int unsigned PtrW    = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] DepthP = PtrW'(DEPTH);

  wr_state_e state_q, state_d;
  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0] commit_ptr_q, commit_ptr_d;
  logic [PTR_WIDTH:0] rd_ptr_q;
  logic               out_valid_q;
  logic               beat, full, wr_en, rd_en, drop_pulse;
  logic [WordW-1:0]   ram_rdata;

  assign s_axis_tready = ~rst;
  assign beat          = s_axis_tvalid & s_axis_tready;
  // Registered rd_ptr: a read this cycle frees space only from the next cycle on.
  assign full          = (wr_ptr_q - rd_ptr_q) == DepthP;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_en        = 1'b0;
    drop_pulse   = 1'b0;
    if (beat) begin
      unique case (state_q)
        ST_PASS: begin
          if (full) begin
            wr_ptr_d = commit_ptr_q;
            if (s_axis_tlast) begin
              drop_pulse = 1'b1;
            end else begin
              state_d = ST_DROP;
            end
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (s_axis_tlast) begin
              if (s_axis_tuser) begin
                wr_ptr_d   = commit_ptr_q;
                drop_pulse = 1'b1;
              end else begin
                commit_ptr_d = wr_ptr_q + 1'b1;
              end
            end
          end
        end
        ST_DROP: begin
          if (s_axis_tlast) begin
            drop_pulse = 1'b1;
            state_d    = ST_PASS;
          end
        end
        default: state_d = ST_PASS;
      endcase
    end
  end

  assign rd_en = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || m_axis_tready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_PASS;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      if (rd_en) begin
        rd_ptr_q    <= rd_ptr_q + 1'b1;
        out_valid_q <= 1'b1;
      end else if (m_axis_tready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // The RAM read register doubles as the output register.
  tx_fifo_ram #(
    .Width(WordW),
    .Depth(DEPTH),
    .AddrW(PTR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr_q[PTR_WIDTH-1:0]),
    .wdata({s_axis_tlast, s_axis_tdata}),
    .re   (rd_en),
    .raddr(rd_ptr_q[PTR_WIDTH-1:0]),
    .rdata(ram_rdata)
  );

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_valid_q ? ram_rdata[DATA_WIDTH-1:0] : '0;
  assign m_axis_tlast  = out_valid_q & ram_rdata[LastBit];
  assign m_axis_tuser  = 1'b0;
  assign drop          = drop_pulse;
  assign frame_avail   = (commit_ptr_q != rd_ptr_q) | out_valid_q;

`ifdef TX_FRAME_FIFO_STATS_EN
  logic [STATS_W-1:0] sent_q, dropped_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sent_q    <= '0;
      dropped_q <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast && (sent_q != '1)) begin
        sent_q <= sent_q + 1'b1;
      end
      if (drop_pulse && (dropped_q != '1)) begin
        dropped_q <= dropped_q + 1'b1;
      end
    end
  end

  assign frames_sent    = sent_q;
  assign frames_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_tx_frame_fifo.sv
// Directed bench for tx_frame_fifo at DEPTH=16: latency, drops, overflow, wrap and mid-frame reset.
module tb_tx_frame_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tready, s_tlast, s_tuser;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tready, m_tlast, m_tuser;
  logic          drop, frame_avail;
`ifdef TX_FRAME_FIFO_STATS_EN
  logic [15:0]   frames_sent, frames_dropped;
`endif

  tx_frame_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .s_axis_tuser (s_tuser),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .m_axis_tuser (m_tuser),
    .drop         (drop),
    .frame_avail  (frame_avail)
`ifdef TX_FRAME_FIFO_STATS_EN
    ,
    .frames_sent   (frames_sent),
    .frames_dropped(frames_dropped)
`endif
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [8:0] rx_q[$];
  int         drop_cnt = 0;
  logic       mon_en = 1'b0;
  logic       hold_v = 1'b0;
  logic [8:0] hold_w = '0;
  logic       rst_d = 1'b1;
  logic       rand_en = 1'b0;
  int         rx_rd = 0;
  int         drop_base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: collects handshakes and checks hold-while-stalled.
  always @(negedge clk) begin
    if (mon_en) begin
      if (drop) begin
        drop_cnt++;
        check("drop_on_tlast", {31'd0, s_tvalid & s_tlast}, 32'd1);
      end
      if (hold_v && !rst_d) begin
        check("stall_valid", {31'd0, m_tvalid}, 32'd1);
        check("stall_word", {23'd0, m_tlast, m_tdata}, {23'd0, hold_w});
      end
      if (m_tvalid && m_tready) rx_q.push_back({m_tlast, m_tdata});
      hold_v = m_tvalid && !m_tready;
      hold_w = {m_tlast, m_tdata};
    end
    rst_d = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_en) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic cycles(input int n);
    repeat (n) step();
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input logic u);
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = l;
    s_tuser  = u;
    step();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] base, input int len, input logic u);
    for (int i = 0; i < len; i++) send_beat(base + 8'(i), (i == len - 1), u);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] base, input int len);
    for (int i = 0; i < len; i++) begin
      logic [8:0] w;
      w = (rx_rd < rx_q.size()) ? rx_q[rx_rd] : 9'h1FF;
      check(tag, {23'd0, w}, {23'd0, (i == len - 1), base + 8'(i)});
      rx_rd++;
    end
  endtask

  task automatic expect_no_more(input string tag);
    check(tag, rx_q.size() - rx_rd, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b1;
    cycles(2);
    @(negedge clk);
    check("rst_s_tready", {31'd0, s_tready}, 32'd0);
    check("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_m_tdata", {24'd0, m_tdata}, 32'd0);
    check("rst_m_tlast", {31'd0, m_tlast}, 32'd0);
    check("rst_drop", {31'd0, drop}, 32'd0);
    check("rst_frame_avail", {31'd0, frame_avail}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    step();
    check("s_tready_run", {31'd0, s_tready}, 32'd1);
    check("m_tuser", {31'd0, m_tuser}, 32'd0);

    // 5-byte frame: tvalid rises two cycles after the tlast beat.
    drop_base = drop_cnt;
    send_frame(8'h01, 5, 1'b0);
    @(negedge clk);
    check("lat_n1_valid", {31'd0, m_tvalid}, 32'd0);
    check("lat_n1_avail", {31'd0, frame_avail}, 32'd1);
    step();
    @(negedge clk);
    check("lat_n2_valid", {31'd0, m_tvalid}, 32'd1);
    check("lat_n2_data", {24'd0, m_tdata}, 32'h01);
    cycles(8);
    expect_frame("f5", 8'h01, 5);
    expect_no_more("f5_extra");
    check("f5_drops", drop_cnt - drop_base, 32'd0);
    check("f5_avail_idle", {31'd0, frame_avail}, 32'd0);

    // Oversized frame dropped, next frame intact.
    drop_base = drop_cnt;
    send_frame(8'h40, 20, 1'b0);
    check("big_drop", drop_cnt - drop_base, 32'd1);
    send_frame(8'hA0, 4, 1'b0);
    cycles(8);
    expect_frame("after_big", 8'hA0, 4);
    expect_no_more("after_big_extra");

    // Errored frame: dropped, never visible.
    drop_base = drop_cnt;
    for (int i = 0; i < 6; i++) begin
      send_beat(8'h60 + 8'(i), (i == 5), (i == 5));
      check("bad_avail", {31'd0, frame_avail}, 32'd0);
    end
    check("bad_drop", drop_cnt - drop_base, 32'd1);
    cycles(4);
    expect_no_more("bad_extra");

    // Overflow with output stalled: third frame dropped.
    m_tready  = 1'b0;
    drop_base = drop_cnt;
    send_frame(8'h10, 6, 1'b0);
    send_frame(8'h20, 6, 1'b0);
    send_frame(8'h30, 6, 1'b0);
    check("ovf_drop", drop_cnt - drop_base, 32'd1);
    cycles(3);
    @(negedge clk);
    check("ovf_hold_valid", {31'd0, m_tvalid}, 32'd1);
    check("ovf_hold_data", {24'd0, m_tdata}, 32'h10);
    check("ovf_avail", {31'd0, frame_avail}, 32'd1);
    m_tready = 1'b1;
    cycles(16);
    expect_frame("ovf_f1", 8'h10, 6);
    expect_frame("ovf_f2", 8'h20, 6);
    expect_no_more("ovf_extra");

    // Random backpressure across several pointer wraps.
    rand_en   = 1'b1;
    drop_base = drop_cnt;
    for (int k = 0; k < 10; k++) begin
      send_frame(8'h80 + 8'(k * 8), 8, 1'b0);
      for (int c = 0; c < 200 && (rx_q.size() - rx_rd) < 8; c++) step();
      expect_frame("wrap", 8'h80 + 8'(k * 8), 8);
    end
    expect_no_more("wrap_extra");
    check("wrap_drops", drop_cnt - drop_base, 32'd0);
    rand_en  = 1'b0;
    m_tready = 1'b1;

    // Reset in the middle of output.
    send_frame(8'hC0, 10, 1'b0);
    cycles(5);
    rst = 1'b1;
    step();
    @(negedge clk);
    check("midrst_valid", {31'd0, m_tvalid}, 32'd0);
    check("midrst_avail", {31'd0, frame_avail}, 32'd0);
    rst = 1'b0;
    step();
    rx_rd = rx_q.size();
    send_frame(8'hE0, 3, 1'b0);
    cycles(6);
    expect_frame("post_rst", 8'hE0, 3);
    expect_no_more("post_rst_extra");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
